bus_bridge: RTL and testbench
=============================

Name: bus_bridge

Overview:
- Bus responder between the CPU data-bus initiator and the memory/peripheral side.
- Decodes the CPU bus address, routes reads and writes to the data RAM, and implements memory-mapped peripherals: LED register, switch/button inputs and 8-digit seven-segment display scanning.
- Sits at the top level beside the CPU core, DRAM and board I/O pins.

Parameters:
- SCAN_DIV, 20000: cpu_clk cycles per display digit slot; legal range is 2 or greater.
- SW_W, 24: switch and LED width.

Ports:
- cpu_clk  in  1  system clock.
- cpu_rst  in  1  reset; asynchronous, active-high.
- Bus_addr  in  32  byte address from the CPU.
- Bus_rdata  out  32  read data to the CPU.
- Bus_wen  in  1  write enable from the CPU.
- Bus_wdata  in  32  write data from the CPU.
- dram_addr  out  14  DRAM word address.
- dram_rdata  in  32  DRAM read data.
- dram_wen  out  1  DRAM write enable.
- dram_wdata  out  32  DRAM write data.
- sw  in  SW_W  raw board switches.
- button  in  5  raw board buttons.
- led  out  SW_W  LED drive.
- dig_en  out  8  digit enables, active-low.
- dig_seg  out  8  segments {DP,G,F,E,D,C,B,A}, active-low.

Behaviour:
- Clock and reset: one clock, cpu_clk; cpu_rst is asynchronous and active-high. All registers clear immediately on cpu_rst assertion.

- Address decode:
  - Full 32-bit compare for peripherals.
  - Peripheral window is 0xFFFF_F000 to 0xFFFF_FFFF; everything else is DRAM.
  - Register map:
    - DIG = 0xFFFF_F000
    - TCNT = 0xFFFF_F020
    - TDIV = 0xFFFF_F024
    - LED = 0xFFFF_F060
    - SW = 0xFFFF_F070
    - BTN = 0xFFFF_F078

- DRAM path:
  - dram_addr = Bus_addr[15:2].
  - dram_wdata = Bus_wdata.
  - dram_wen = Bus_wen AND address is not in the peripheral window.
  - DRAM reads are combinational passthrough.

- Read mux (combinational, same cycle):
  - DRAM region: dram_rdata.
  - DIG: digit register.
  - LED: zero-extended led.
  - SW: zero-extended synchronized switches.
  - BTN: zero-extended synchronized buttons.
  - Unmapped peripheral addresses read 0.

- Writes:
  - Take effect on the cpu_clk rising edge with Bus_wen = 1.
  - DIG accepts all 32 bits; LED takes Bus_wdata[SW_W-1:0].
  - Writes to SW, BTN or unmapped peripheral addresses are ignored and produce no DRAM write.

- Input synchronizers:
  - sw and button each pass through 2 flops.
  - A pin change is visible on a read 2 edges later.
  - Both synchronizer stages reset to 0.

- Display scan:
  - Prescaler counts 0 to SCAN_DIV-1 and wraps to 0. On the wrap it asserts a tick.
  - On each tick, the 3-bit digit index advances 0 to 7, then wraps from 7 back to 0.
  - Digit i shows nibble DIG[4i+3:4i], decoded as hex 0-F to segments; DP is always off (1).
  - dig_en and dig_seg are registered from the index and DIG value, so 1 cycle of latency.
  - A DIG write is shown at the next registered update. The scan position is not disturbed.

- Reset values:
  - led = 0, DIG = 0, prescaler = 0, index = 0.
  - dig_en = 8'hFF and dig_seg = 8'hFF (blank).
  - The first edge after reset release drives dig_en = 8'hFE, dig_seg = 8'hC0 (digit "0").

- Simultaneous events:
  - A scan tick and a DIG write in the same cycle are both applied.
  - Asserting cpu_rst mid-scan blanks the display immediately.

Optional Feature:
- Macro: BRIDGE_TIMER_EN.
- Defined: 32-bit timer.
  - TDIV is read/write, reset value 0.
  - Prescale counter p: when p == TDIV, TCNT increments (wrapping from 0xFFFF_FFFF to 0) and p clears to 0; otherwise p increments.
  - A TCNT write loads Bus_wdata and clears p. The write wins over a same-cycle increment.
  - A TDIV write clears p.
- Not defined: no timer logic is built. TCNT and TDIV read 0 and ignore writes.

Test Plan:
- Reset, then write 0x0000_ABCD to LED -> led = 0x00ABCD next edge; a read of LED returns 0x0000_ABCD; dram_wen stays 0.
- Bus_wen=1, Bus_addr=0x0000_1004, Bus_wdata=0x1234_5678 -> dram_wen=1, dram_addr=0x0401; a read at the same address returns dram_rdata.
- sw changes 0 to 0x00_00FF at edge k -> read of SW returns 0 through edge k+1 and 0x0000_00FF from edge k+2.
- SCAN_DIV=4, DIG=0x7654_3210 -> dig_en cycles FE, FD, ... 7F, FE, each held 4 cycles; dig_seg follows 0xC0, 0xF9, 0xA4, ... (digits 0-7).
- With BRIDGE_TIMER_EN defined: TDIV=2, TCNT written 0xFFFF_FFFE -> TCNT reads 0xFFFF_FFFF after 3 cycles and 0 after 6; without the macro, TCNT reads 0.
- Assert cpu_rst mid-scan with led=0xFF -> led=0, dig_en=0xFF immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bus_bridge_if.sv
// CPU data-bus bundle shared between the CPU initiator and the bus_bridge responder.
// Addresses are byte addresses; the read data is combinational in the same cycle.
interface bus_bridge_if;
   logic [31:0] Bus_addr;
   logic [31:0] Bus_rdata;
   logic        Bus_wen;
   logic [31:0] Bus_wdata;

   modport master (
      output Bus_addr,
      output Bus_wen,
      output Bus_wdata,
      input  Bus_rdata
   );

   modport slave (
      input  Bus_addr,
      input  Bus_wen,
      input  Bus_wdata,
      output Bus_rdata
   );
endinterface

// File: rtl/bus_bridge.sv
// CPU bus responder: DRAM routing plus LED, switch/button, seven-segment scan peripherals.
// Optional 32-bit timer (TCNT/TDIV) is built only when BRIDGE_TIMER_EN is defined.
module bus_bridge #(
   parameter int SCAN_DIV = 20000,
   parameter int SW_W     = 24
) (
   input  logic            cpu_clk,
   input  logic            cpu_rst,
   bus_bridge_if.slave     bus,
   output logic [13:0]     dram_addr,
   input  logic [31:0]     dram_rdata,
   output logic            dram_wen,
   output logic [31:0]     dram_wdata,
   input  logic [SW_W-1:0] sw,
   input  logic [4:0]      button,
   output logic [SW_W-1:0] led,
   output logic [7:0]      dig_en,
   output logic [7:0]      dig_seg
);

   localparam logic [31:0] ADDR_DIG  = 32'hFFFF_F000;
   localparam logic [31:0] ADDR_TCNT = 32'hFFFF_F020;
   localparam logic [31:0] ADDR_TDIV = 32'hFFFF_F024;
   localparam logic [31:0] ADDR_LED  = 32'hFFFF_F060;
   localparam logic [31:0] ADDR_SW   = 32'hFFFF_F070;
   localparam logic [31:0] ADDR_BTN  = 32'hFFFF_F078;

   localparam int            PW         = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

   // Hex digit to active-low {DP,G,F,E,D,C,B,A}; DP stays dark.
   function automatic logic [7:0] seg_decode(input logic [3:0] nib);
      logic [7:0] seg;
      case (nib)
         4'h0: seg = 8'hC0;
         4'h1: seg = 8'hF9;
         4'h2: seg = 8'hA4;
         4'h3: seg = 8'hB0;
         4'h4: seg = 8'h99;
         4'h5: seg = 8'h92;
         4'h6: seg = 8'h82;
         4'h7: seg = 8'hF8;
         4'h8: seg = 8'h80;
         4'h9: seg = 8'h90;
         4'hA: seg = 8'h88;
         4'hB: seg = 8'h83;
         4'hC: seg = 8'hC6;
         4'hD: seg = 8'hA1;
         4'hE: seg = 8'h86;
         default: seg = 8'h8E;
      endcase
      return seg;
   endfunction

   logic            in_periph;
   logic            sel_dig, sel_tcnt, sel_tdiv, sel_led, sel_sw, sel_btn;
   logic            wr_dig, wr_led;
   logic [31:0]     rd_data;
   logic [31:0]     tcnt_rd, tdiv_rd;

   logic [SW_W-1:0] led_q, led_d;
   logic [31:0]     dig_q, dig_d;
   logic [SW_W-1:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
   logic [4:0]      btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      dig_en_q, dig_en_d;
   logic [7:0]      dig_seg_q, dig_seg_d;
   logic            tick;

   assign in_periph = (bus.Bus_addr[31:12] == 20'hFFFFF);
   assign sel_dig   = (bus.Bus_addr == ADDR_DIG);
   assign sel_tcnt  = (bus.Bus_addr == ADDR_TCNT);
   assign sel_tdiv  = (bus.Bus_addr == ADDR_TDIV);
   assign sel_led   = (bus.Bus_addr == ADDR_LED);
   assign sel_sw    = (bus.Bus_addr == ADDR_SW);
   assign sel_btn   = (bus.Bus_addr == ADDR_BTN);

   assign wr_dig = bus.Bus_wen & sel_dig;
   assign wr_led = bus.Bus_wen & sel_led;

   assign dram_addr  = bus.Bus_addr[15:2];
   assign dram_wdata = bus.Bus_wdata;
   assign dram_wen   = bus.Bus_wen & ~in_periph;

   always_comb begin
      rd_data = '0;
      if (!in_periph)    rd_data = dram_rdata;
      else if (sel_dig)  rd_data = dig_q;
      else if (sel_tcnt) rd_data = tcnt_rd;
      else if (sel_tdiv) rd_data = tdiv_rd;
      else if (sel_led)  rd_data = 32'(led_q);
      else if (sel_sw)   rd_data = 32'(sw_s2_q);
      else if (sel_btn)  rd_data = 32'(btn_s2_q);
   end

   assign bus.Bus_rdata = rd_data;

   always_comb begin
      led_d    = wr_led ? bus.Bus_wdata[SW_W-1:0] : led_q;
      dig_d    = wr_dig ? bus.Bus_wdata : dig_q;
      sw_s1_d  = sw;
      sw_s2_d  = sw_s1_q;
      btn_s1_d = button;
      btn_s2_d = btn_s1_q;
   end

   // Scan outputs are taken from the pre-update index and DIG, so they trail the index by one cycle.
   always_comb begin
      tick      = (presc_q == PRESC_LAST);
      presc_d   = tick ? '0 : presc_q + 1'b1;
      idx_d     = tick ? idx_q + 3'd1 : idx_q;
      dig_en_d  = ~(8'h01 << idx_q);
      dig_seg_d = seg_decode(dig_q[{idx_q, 2'b00} +: 4]);
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         led_q     <= '0;
         dig_q     <= '0;
         sw_s1_q   <= '0;
         sw_s2_q   <= '0;
         btn_s1_q  <= '0;
         btn_s2_q  <= '0;
         presc_q   <= '0;
         idx_q     <= '0;
         dig_en_q  <= 8'hFF;
         dig_seg_q <= 8'hFF;
      end else begin
         led_q     <= led_d;
         dig_q     <= dig_d;
         sw_s1_q   <= sw_s1_d;
         sw_s2_q   <= sw_s2_d;
         btn_s1_q  <= btn_s1_d;
         btn_s2_q  <= btn_s2_d;
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         dig_en_q  <= dig_en_d;
         dig_seg_q <= dig_seg_d;
      end
   end

   assign led     = led_q;
   assign dig_en  = dig_en_q;
   assign dig_seg = dig_seg_q;

`ifdef BRIDGE_TIMER_EN
   logic        wr_tcnt, wr_tdiv;
   logic [31:0] tcnt_q, tcnt_d, tdiv_q, tdiv_d, tpre_q, tpre_d;

   assign wr_tcnt = bus.Bus_wen & sel_tcnt;
   assign wr_tdiv = bus.Bus_wen & sel_tdiv;

   // A TCNT write overrides any increment landing in the same cycle.
   always_comb begin
      tcnt_d = tcnt_q;
      tdiv_d = tdiv_q;
      tpre_d = tpre_q + 32'd1;
      if (tpre_q == tdiv_q) begin
         tcnt_d = tcnt_q + 32'd1;
         tpre_d = '0;
      end
      if (wr_tdiv) begin
         tdiv_d = bus.Bus_wdata;
         tpre_d = '0;
      end
      if (wr_tcnt) begin
         tcnt_d = bus.Bus_wdata;
         tpre_d = '0;
      end
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         tcnt_q <= '0;
         tdiv_q <= '0;
         tpre_q <= '0;
      end else begin
         tcnt_q <= tcnt_d;
         tdiv_q <= tdiv_d;
         tpre_q <= tpre_d;
      end
   end

   assign tcnt_rd = tcnt_q;
   assign tdiv_rd = tdiv_q;
`else
   assign tcnt_rd = '0;
   assign tdiv_rd = '0;
`endif

endmodule

// File: tb/tb_bus_bridge.sv
// Scoreboard bench for bus_bridge: the driver queues expected values, the monitor pops and compares.
`timescale 1ns/1ps
module tb_bus_bridge;
   localparam int SW_W = 24;

   localparam logic [31:0] ADDR_DIG  = 32'hFFFF_F000;
   localparam logic [31:0] ADDR_TCNT = 32'hFFFF_F020;
   localparam logic [31:0] ADDR_TDIV = 32'hFFFF_F024;
   localparam logic [31:0] ADDR_LED  = 32'hFFFF_F060;
   localparam logic [31:0] ADDR_SW   = 32'hFFFF_F070;
   localparam logic [31:0] ADDR_BTN  = 32'hFFFF_F078;
   localparam logic [31:0] DIG_A     = 32'h7654_3210;
   localparam logic [31:0] DIG_B     = 32'h89AB_CDEF;

   localparam int S_RDATA = 0, S_LED = 1, S_EN = 2, S_SEG = 3, S_DWEN = 4, S_DADDR = 5, S_DWDATA = 6;

   logic            clk = 1'b0;
   logic            rst;
   logic [13:0]     dram_addr;
   logic [31:0]     dram_rdata;
   logic            dram_wen;
   logic [31:0]     dram_wdata;
   logic [SW_W-1:0] sw;
   logic [4:0]      button;
   logic [SW_W-1:0] led;
   logic [7:0]      dig_en;
   logic [7:0]      dig_seg;

   bus_bridge_if bif ();

   bus_bridge #(.SCAN_DIV(4), .SW_W(SW_W)) dut (
      .cpu_clk    (clk),
      .cpu_rst    (rst),
      .bus        (bif.slave),
      .dram_addr  (dram_addr),
      .dram_rdata (dram_rdata),
      .dram_wen   (dram_wen),
      .dram_wdata (dram_wdata),
      .sw         (sw),
      .button     (button),
      .led        (led),
      .dig_en     (dig_en),
      .dig_seg    (dig_seg)
   );

   always #5 clk = ~clk;

   // Simple DRAM stand-in: data is a fixed pattern of the word address.
   assign dram_rdata = 32'hA5A5_0000 ^ {18'h0, dram_addr};

   logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } chk_t;

   chk_t sb [$];
   int   n_checks = 0;
   int   n_err    = 0;
   event chk_ev;

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         S_RDATA:  return bif.Bus_rdata;
         S_LED:    return 32'(led);
         S_EN:     return 32'(dig_en);
         S_SEG:    return 32'(dig_seg);
         S_DWEN:   return 32'(dram_wen);
         S_DADDR:  return 32'(dram_addr);
         default:  return dram_wdata;
      endcase
   endfunction

   chk_t        cur;
   logic [31:0] got;
   always @(chk_ev) begin
      while (sb.size() > 0) begin
         cur = sb.pop_front();
         got = observe(cur.sel);
         n_checks++;
         if (got !== cur.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", cur.name, got, cur.exp, $time);
         end
      end
   end

   task automatic chk(input string name, input int sel, input logic [31:0] exp);
      chk_t c;
      c.name = name;
      c.sel  = sel;
      c.exp  = exp;
      sb.push_back(c);
   endtask

   task automatic fire();
      ->chk_ev;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
      bif.Bus_addr = addr;
      bif.Bus_wen  = 1'b0;
      #1;
      chk(name, S_RDATA, exp);
      fire();
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic exp_dwen);
      bif.Bus_addr  = addr;
      bif.Bus_wdata = data;
      bif.Bus_wen   = 1'b1;
      #1;
      chk("wr_dram_wen", S_DWEN, 32'(exp_dwen));
      fire();
      step();
      bif.Bus_wen = 1'b0;
   endtask

   initial begin
      logic [31:0] dval;
      logic [7:0]  en_exp;
      logic [3:0]  nib;
      int          k;

      rst           = 1'b1;
      bif.Bus_addr  = '0;
      bif.Bus_wdata = '0;
      bif.Bus_wen   = 1'b0;
      sw            = '0;
      button        = '0;

      repeat (3) @(posedge clk);
      #2;
      chk("rst_dig_en", S_EN, 32'h0000_00FF);
      chk("rst_dig_seg", S_SEG, 32'h0000_00FF);
      chk("rst_led", S_LED, 32'h0);
      fire();
      rd("rst_rd_dig", ADDR_DIG, 32'h0);

      // Release reset with a DIG write already on the bus for edge 1.
      rst           = 1'b0;
      bif.Bus_addr  = ADDR_DIG;
      bif.Bus_wdata = DIG_A;
      bif.Bus_wen   = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         step();
         if (n == 1 || n == 21) bif.Bus_wen = 1'b0;
         k      = ((n - 1) / 4) % 8;
         dval   = (n >= 22) ? DIG_B : DIG_A;
         en_exp = ~(8'h01 << k);
         nib    = dval[4*k +: 4];
         chk("scan_en", S_EN, 32'(en_exp));
         chk("scan_seg", S_SEG, 32'(seg_tab[nib]));
         fire();
         if (n == 20) begin
            bif.Bus_wdata = DIG_B;
            bif.Bus_wen   = 1'b1;
         end
      end
      rd("rd_dig", ADDR_DIG, DIG_B);

      step();
      bif.Bus_addr  = 32'h0000_1004;
      bif.Bus_wdata = 32'h1234_5678;
      bif.Bus_wen   = 1'b1;
      #1;
      chk("dram_wen", S_DWEN, 32'h1);
      chk("dram_addr", S_DADDR, 32'h0000_0401);
      chk("dram_wdata", S_DWDATA, 32'h1234_5678);
      chk("dram_rd", S_RDATA, 32'hA5A5_0401);
      fire();
      step();
      bif.Bus_wen = 1'b0;
      rd("dram_rd_edge", 32'hFFFF_EFFC, 32'hA5A5_3BFF);

      wr(ADDR_LED, 32'h0000_ABCD, 1'b0);
      chk("led_val", S_LED, 32'h0000_ABCD);
      fire();
      rd("rd_led", ADDR_LED, 32'h0000_ABCD);
      wr(ADDR_LED, 32'hFF12_3456, 1'b0);
      rd("rd_led_trunc", ADDR_LED, 32'h0012_3456);

      wr(ADDR_SW, 32'hFFFF_FFFF, 1'b0);
      rd("rd_unmapped", 32'hFFFF_F100, 32'h0);
      rd("rd_sw_idle", ADDR_SW, 32'h0);

      step();
      sw = 24'h00_00FF;
      step();
      rd("sw_sync1", ADDR_SW, 32'h0);
      step();
      rd("sw_sync2", ADDR_SW, 32'h0000_00FF);

      button = 5'h15;
      step();
      rd("btn_sync1", ADDR_BTN, 32'h0);
      step();
      rd("btn_sync2", ADDR_BTN, 32'h0000_0015);

`ifdef BRIDGE_TIMER_EN
      wr(ADDR_TDIV, 32'h2, 1'b0);
      wr(ADDR_TCNT, 32'hFFFF_FFFE, 1'b0);
      rd("tcnt_load", ADDR_TCNT, 32'hFFFF_FFFE);
      rd("tdiv_rd", ADDR_TDIV, 32'h2);
      repeat (3) step();
      rd("tcnt_inc", ADDR_TCNT, 32'hFFFF_FFFF);
      repeat (2) step();
      rd("tcnt_hold", ADDR_TCNT, 32'hFFFF_FFFF);
      step();
      rd("tcnt_wrap", ADDR_TCNT, 32'h0);
`else
      wr(ADDR_TDIV, 32'h2, 1'b0);
      wr(ADDR_TCNT, 32'hFFFF_FFFE, 1'b0);
      rd("tcnt_absent", ADDR_TCNT, 32'h0);
      rd("tdiv_absent", ADDR_TDIV, 32'h0);
`endif

      wr(ADDR_LED, 32'h0000_00FF, 1'b0);
      chk("led_ff", S_LED, 32'h0000_00FF);
      fire();
      rst = 1'b1;
      #1;
      chk("arst_led", S_LED, 32'h0);
      chk("arst_dig_en", S_EN, 32'h0000_00FF);
      chk("arst_dig_seg", S_SEG, 32'h0000_00FF);
      fire();
      rd("arst_rd_dig", ADDR_DIG, 32'h0);
      step();
      rst = 1'b0;
      step();

      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
